// File: rtl/fmul_sched.sv
// fmul_sched: round-robin scheduler sharing one pipelined fmul core.
// Sticky per-requester exception flags are built when FMUL_SCHED_EXC_EN is defined.

module fmul (
    input  logic [31:0] i_x1,
    input  logic [31:0] i_x2,
    output logic [31:0] o_y,
    output logic        o_ovf,
    output logic        o_unf
);
    logic [7:0]        w_e1;
    logic [7:0]        w_e2;
    logic [23:0]       w_m1;
    logic [23:0]       w_m2;
    logic [47:0]       w_p;
    logic              w_s;
    logic signed [9:0] w_exp;
    logic [22:0]       w_frac;
    logic              w_unused;

    assign w_e1   = i_x1[30:23];
    assign w_e2   = i_x2[30:23];
    assign w_m1   = {1'b1, i_x1[22:0]};
    assign w_m2   = {1'b1, i_x2[22:0]};
    assign w_s    = i_x1[31] ^ i_x2[31];
    assign w_p    = w_m1 * w_m2;
    assign w_exp  = $signed({2'b00, w_e1}) + $signed({2'b00, w_e2})
                  - 10'sd127 + $signed({9'd0, w_p[47]});
    assign w_frac = w_p[47] ? w_p[46:24] : w_p[45:23];

    // Product bits below the kept fraction are truncated away.
    assign w_unused = &{1'b0, w_p[22:0]};

    // Classify: zero/denormal operand gives +0, inf/NaN or large exponent
    // saturates to signed infinity, small exponent flushes to signed zero.
    always_comb begin
        o_y   = '0;
        o_ovf = 1'b0;
        o_unf = 1'b0;
        if (w_e1 == 8'h00 || w_e2 == 8'h00) begin
            o_y = '0;
        end else if (w_e1 == 8'hFF || w_e2 == 8'hFF) begin
            o_y   = {w_s, 8'hFF, 23'h0};
            o_ovf = 1'b1;
        end else if (w_exp >= 10'sd255) begin
            o_y   = {w_s, 8'hFF, 23'h0};
            o_ovf = 1'b1;
        end else if (w_exp <= 10'sd0) begin
            o_y   = {w_s, 31'h0};
            o_unf = 1'b1;
        end else begin
            o_y = {w_s, w_exp[7:0], w_frac};
        end
    end
endmodule

module fmul_sched #(
    parameter int NREQ = 4,
    parameter int LAT  = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   x1_in,
    input  logic [32*NREQ-1:0]   x2_in,
    input  logic                 hold,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_y,
    output logic                 rsp_ovf,
    output logic                 rsp_unf,
    output logic                 busy,
    output logic [2*NREQ-1:0]    exc_flags,
    input  logic [NREQ-1:0]      exc_clr
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_idx;
    logic [PW-1:0] w_k;
    logic          w_found;
    logic          w_issue;

    logic          r_s0_v;
    logic [PW-1:0] r_s0_tag;
    logic [31:0]   r_s0_x1;
    logic [31:0]   r_s0_x2;

    logic          r_v   [1:LAT-1];
    logic [PW-1:0] r_tag [1:LAT-1];
    logic [31:0]   r_y   [1:LAT-1];

    logic [31:0]   w_y;
    logic          w_ovf;
    logic          w_unf;

    // Search for the first request starting at the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_k     = r_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[w_k]) begin
                w_found = 1'b1;
                w_idx   = w_k;
            end
            w_k = (w_k == PW'(NREQ-1)) ? '0 : w_k + 1'b1;
        end
    end

    assign w_issue = w_found & ~hold & rstn;

    // One-hot grant for the selected requester.
    always_comb begin
        gnt = '0;
        if (w_issue) begin
            gnt[w_idx] = 1'b1;
        end
    end

    // Pointer moves past the granted requester; idle cycles leave it alone.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            r_ptr <= (w_idx == PW'(NREQ-1)) ? '0 : w_idx + 1'b1;
        end
    end

    // Stage 0: capture the granted operands and tag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s0_v   <= 1'b0;
            r_s0_tag <= '0;
            r_s0_x1  <= '0;
            r_s0_x2  <= '0;
        end else begin
            r_s0_v <= w_issue;
            if (w_issue) begin
                r_s0_tag <= w_idx;
                r_s0_x1  <= x1_in[32*w_idx +: 32];
                r_s0_x2  <= x2_in[32*w_idx +: 32];
            end
        end
    end

    fmul u_fmul (
        .i_x1  (r_s0_x1),
        .i_x2  (r_s0_x2),
        .o_y   (w_y),
        .o_ovf (w_ovf),
        .o_unf (w_unf)
    );

    // Product, tag and valid march through the remaining delay stages.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 1; s < LAT; s++) begin
                r_v[s]   <= 1'b0;
                r_tag[s] <= '0;
                r_y[s]   <= '0;
            end
        end else begin
            r_v[1]   <= r_s0_v;
            r_tag[1] <= r_s0_tag;
            r_y[1]   <= w_y;
            for (int s = 2; s < LAT; s++) begin
                r_v[s]   <= r_v[s-1];
                r_tag[s] <= r_tag[s-1];
                r_y[s]   <= r_y[s-1];
            end
        end
    end

    assign rsp_y = r_y[LAT-1];

    // Route the result strobe back to the requester named by the tag.
    always_comb begin
        rsp_valid = '0;
        if (r_v[LAT-1]) begin
            rsp_valid[r_tag[LAT-1]] = 1'b1;
        end
    end

    // Busy whenever any stage holds a live operation.
    always_comb begin
        busy = r_s0_v;
        for (int s = 1; s < LAT; s++) begin
            busy = busy | r_v[s];
        end
    end

`ifdef FMUL_SCHED_EXC_EN
    logic              r_ovf [1:LAT-1];
    logic              r_unf [1:LAT-1];
    logic [2*NREQ-1:0] r_exc;
    logic              w_zero;

    assign w_zero = (r_s0_x1 == 32'h0) || (r_s0_x2 == 32'h0);

    // Exception flags travel with the product, masked for exact-zero operands.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 1; s < LAT; s++) begin
                r_ovf[s] <= 1'b0;
                r_unf[s] <= 1'b0;
            end
        end else begin
            r_ovf[1] <= w_ovf & ~w_zero;
            r_unf[1] <= w_unf & ~w_zero;
            for (int s = 2; s < LAT; s++) begin
                r_ovf[s] <= r_ovf[s-1];
                r_unf[s] <= r_unf[s-1];
            end
        end
    end

    // Sticky flags per requester; a same-cycle response overrides a clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_exc <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                r_exc[2*i +: 2] <=
                    (exc_clr[i] ? 2'b00 : r_exc[2*i +: 2]) |
                    (rsp_valid[i] ? {r_ovf[LAT-1], r_unf[LAT-1]} : 2'b00);
            end
        end
    end

    assign rsp_ovf   = r_ovf[LAT-1];
    assign rsp_unf   = r_unf[LAT-1];
    assign exc_flags = r_exc;
`else
    logic w_unused;

    assign w_unused  = &{1'b0, exc_clr, w_ovf, w_unf};
    assign rsp_ovf   = 1'b0;
    assign rsp_unf   = 1'b0;
    assign exc_flags = '0;
`endif
endmodule

// File: tb/tb_fmul_sched.sv
// tb_fmul_sched: directed vectors for the shared fmul scheduler.
// Flag expectations follow FMUL_SCHED_EXC_EN.

module tb_fmul_sched;
    localparam int NREQ = 4;
    localparam int LAT  = 3;
`ifdef FMUL_SCHED_EXC_EN
    localparam bit EXC = 1'b1;
`else
    localparam bit EXC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              hold = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   exc_clr = '0;
    logic [32*NREQ-1:0] x1_in = '0;
    logic [32*NREQ-1:0] x2_in = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [31:0]       rsp_y;
    logic              rsp_ovf;
    logic              rsp_unf;
    logic              busy;
    logic [2*NREQ-1:0] exc_flags;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fmul_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .x1_in     (x1_in),
        .x2_in     (x2_in),
        .hold      (hold),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_y     (rsp_y),
        .rsp_ovf   (rsp_ovf),
        .rsp_unf   (rsp_unf),
        .busy      (busy),
        .exc_flags (exc_flags),
        .exc_clr   (exc_clr)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a,
                          input logic [31:0] b);
        x1_in[32*i +: 32] = a;
        x2_in[32*i +: 32] = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req = 4'b1111;
        #2;
        check("rst_gnt", gnt, 4'b0000);
        check("rst_rsp", rsp_valid, 4'b0000);
        check("rst_y", rsp_y, 32'h0);
        check("rst_flags", {rsp_ovf, rsp_unf}, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_exc", exc_flags, 8'h00);
        tick();
        tick();
        check("rst_gnt_held", gnt, 4'b0000);
        req  = '0;
        rstn = 1'b1;

        // single op 1.0 * 2.0
        tick();
        set_op(0, 32'h3F800000, 32'h40000000);
        req = 4'b0001;
        #1;
        check("single_gnt", gnt, 4'b0001);
        tick();
        req = '0;
        #1;
        check("single_busy", busy, 1'b1);
        tick();
        #1;
        check("single_early", rsp_valid, 4'b0000);
        tick();
        #1;
        check("single_rsp", rsp_valid, 4'b0001);
        check("single_y", rsp_y, 32'h40000000);
        check("single_flags", {rsp_ovf, rsp_unf}, 2'b00);
        tick();
        #1;
        check("single_pulse", rsp_valid, 4'b0000);

        // pointer back to 0 for the round-robin sweep
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            set_op(i, 32'h3F800000, {1'b0, 8'(128 + i), 23'h0});
        end
        for (int c = 0; c < 8 + LAT; c++) begin
            tick();
            req = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) begin
                check("rr_gnt", gnt, 4'b0001 << (c % 4));
            end
            if (c >= LAT) begin
                check("rr_rsp", rsp_valid, 4'b0001 << ((c - LAT) % 4));
                check("rr_y", rsp_y, {1'b0, 8'(128 + ((c - LAT) % 4)), 23'h0});
            end
        end
        tick();
        #1;
        check("rr_idle", busy, 1'b0);

        // wrap from pointer 3 back to 0
        tick();
        req = 4'b0100;
        #1;
        check("wrap_pre", gnt, 4'b0100);
        tick();
        req = 4'b1001;
        #1;
        check("wrap_g3", gnt, 4'b1000);
        tick();
        #1;
        check("wrap_g0", gnt, 4'b0001);
        tick();
        #1;
        check("wrap_g3b", gnt, 4'b1000);
        tick();
        req = '0;
        repeat (LAT) tick();
        #1;
        check("wrap_idle", busy, 1'b0);

        // zero operand masks flags
        tick();
        set_op(1, 32'h00000000, 32'h3F800000);
        req = 4'b0010;
        #1;
        check("zero_gnt", gnt, 4'b0010);
        tick();
        req = '0;
        tick();
        tick();
        #1;
        check("zero_rsp", rsp_valid, 4'b0010);
        check("zero_y", rsp_y, 32'h0);
        check("zero_flags", {rsp_ovf, rsp_unf}, 2'b00);
        tick();
        #1;
        check("zero_exc", exc_flags, 8'h00);

        // overflow sets the sticky pair of requester 1
        tick();
        set_op(1, 32'h7F000000, 32'h7F000000);
        req = 4'b0010;
        #1;
        check("ovf_gnt", gnt, 4'b0010);
        tick();
        req = '0;
        tick();
        tick();
        #1;
        check("ovf_rsp", rsp_valid, 4'b0010);
        check("ovf_y", rsp_y, 32'h7F800000);
        check("ovf_flags", {rsp_ovf, rsp_unf}, {EXC, 1'b0});
        tick();
        #1;
        check("ovf_exc", exc_flags, EXC ? 8'h08 : 8'h00);
        tick();
        exc_clr = 4'b0010;
        #1;
        check("ovf_sticky", exc_flags, EXC ? 8'h08 : 8'h00);
        tick();
        exc_clr = '0;
        #1;
        check("ovf_clr", exc_flags, 8'h00);

        // underflow with a clear in the response cycle: set wins
        tick();
        set_op(1, 32'h00800000, 32'h00800000);
        req = 4'b0010;
        #1;
        check("unf_gnt", gnt, 4'b0010);
        tick();
        req = '0;
        tick();
        tick();
        exc_clr = 4'b0010;
        #1;
        check("unf_rsp", rsp_valid, 4'b0010);
        check("unf_y", rsp_y, 32'h0);
        check("unf_flags", {rsp_ovf, rsp_unf}, {1'b0, EXC});
        tick();
        exc_clr = '0;
        #1;
        check("unf_exc", exc_flags, EXC ? 8'h04 : 8'h00);
        tick();
        exc_clr = 4'b0010;
        tick();
        exc_clr = '0;
        #1;
        check("unf_clr", exc_flags, 8'h00);

        // hold blocks grants while the pipe drains
        tick();
        set_op(2, 32'h3F800000, 32'h40400000);
        req = 4'b0100;
        #1;
        check("hold_pre", gnt, 4'b0100);
        tick();
        hold = 1'b1;
        req  = 4'b0110;
        #1;
        check("hold_gnt", gnt, 4'b0000);
        check("hold_busy", busy, 1'b1);
        tick();
        #1;
        check("hold_gnt2", gnt, 4'b0000);
        tick();
        #1;
        check("hold_rsp", rsp_valid, 4'b0100);
        check("hold_y", rsp_y, 32'h40400000);
        tick();
        #1;
        check("hold_drain", busy, 1'b0);
        check("hold_gnt3", gnt, 4'b0000);

        // reset with two ops in flight
        tick();
        hold = 1'b0;
        req  = 4'b0011;
        set_op(0, 32'h3F800000, 32'h3F800000);
        set_op(1, 32'h3F800000, 32'h3F800000);
        #1;
        check("rst_mid_g0", gnt, 4'b0001);
        tick();
        #1;
        check("rst_mid_g1", gnt, 4'b0010);
        tick();
        req = '0;
        #1;
        check("rst_mid_busy", busy, 1'b1);
        rstn = 1'b0;
        req  = 4'b0011;
        #1;
        check("rst_mid_idle", busy, 1'b0);
        check("rst_mid_rsp", rsp_valid, 4'b0000);
        check("rst_mid_gnt", gnt, 4'b0000);
        tick();
        req  = '0;
        rstn = 1'b1;
        for (int c = 0; c <= LAT; c++) begin
            tick();
            check("rst_after_rsp", rsp_valid, 4'b0000);
            check("rst_after_busy", busy, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
